alu_operand_stage: RTL and testbench

//  ID->EX stage that feeds the RV32I ALU. Buffers decoded instructions in a 2-entry skid buffer with valid/ready

---
 rtl/rv32_alu_pkg.sv | 43 ++++
 rtl/alu_fwd_sel.sv | 27 ++
 rtl/alu_operand_stage.sv | 188 ++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_alu_pkg.sv
// Shared types and widths for the ID->EX operand stage that feeds the RV32I ALU.
package rv32_alu_pkg;

    localparam int XLEN  = 32;
    localparam int OPW   = 4;
    localparam int REGAW = 5;

    // Codes 4'hC..4'hF are undefined and are passed through untouched by the operand stage.
    typedef enum logic [OPW-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLL  = 4'h2,
        ALU_SLT  = 4'h3,
        ALU_SLTU = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_OR   = 4'h8,
        ALU_AND  = 4'h9,
        ALU_LUI  = 4'hA,
        ALU_COPY = 4'hB
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0]  rs1val;
        logic [XLEN-1:0]  rs2val;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [REGAW-1:0] rs1;
        logic [REGAW-1:0] rs2;
        logic [REGAW-1:0] rd;
        logic [OPW-1:0]   op;
        logic             use_pc;
        logic             use_imm;
    } opstage_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } opstage_state_e;

endpackage

// File: rtl/alu_fwd_sel.sv
// Bypass priority mux for one register operand: EX/MEM beats MEM/WB, x0 is never forwarded.
module alu_fwd_sel
    import rv32_alu_pkg::*;
(
    input  logic [REGAW-1:0] rs,
    input  logic [XLEN-1:0]  file_val,
    input  logic             exm_we,
    input  logic [REGAW-1:0] exm_rd,
    input  logic [XLEN-1:0]  exm_data,
    input  logic             mwb_we,
    input  logic [REGAW-1:0] mwb_rd,
    input  logic [XLEN-1:0]  mwb_data,
    output logic [XLEN-1:0]  fwd_val
);

    always_comb begin
        fwd_val = file_val;
        if (rs != '0) begin
            if (exm_we && (exm_rd == rs)) begin
                fwd_val = exm_data;
            end else if (mwb_we && (mwb_rd == rs)) begin
                fwd_val = mwb_data;
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID->EX operand stage: 2-entry skid buffer with writeback snooping and ALU operand selection.
// Define ALU_STAGE_FWD_EN to enable bypass snooping; otherwise operands are fixed at capture.
module alu_operand_stage
    import rv32_alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [REGAW-1:0] in_rs1,
    input  logic [REGAW-1:0] in_rs2,
    input  logic [REGAW-1:0] in_rd,
    input  logic [OPW-1:0]   in_alu_op,
    input  logic             in_use_pc,
    input  logic             in_use_imm,
    input  logic             exm_we,
    input  logic [REGAW-1:0] exm_rd,
    input  logic [XLEN-1:0]  exm_data,
    input  logic             mwb_we,
    input  logic [REGAW-1:0] mwb_rd,
    input  logic [XLEN-1:0]  mwb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  dataA,
    output logic [XLEN-1:0]  dataB,
    output logic [OPW-1:0]   alu_op,
    output logic [REGAW-1:0] out_rd
);

    opstage_state_e state, state_nxt;
    opstage_entry_t head, skid, head_nxt, skid_nxt;
    opstage_entry_t in_entry, head_fwd, skid_fwd;

    logic [XLEN-1:0] in_rs1_fwd, in_rs2_fwd;
    logic [XLEN-1:0] head_rs1_fwd, head_rs2_fwd;
    logic [XLEN-1:0] skid_rs1_fwd, skid_rs2_fwd;
    logic            in_fire, out_fire;

    assign in_fire  = in_valid & in_ready & ~flush;
    assign out_fire = out_valid & out_ready;

`ifdef ALU_STAGE_FWD_EN
    alu_fwd_sel u_in_rs1 (
        .rs(in_rs1), .file_val(in_rs1_data),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .fwd_val(in_rs1_fwd)
    );
    alu_fwd_sel u_in_rs2 (
        .rs(in_rs2), .file_val(in_rs2_data),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .fwd_val(in_rs2_fwd)
    );
    alu_fwd_sel u_head_rs1 (
        .rs(head.rs1), .file_val(head.rs1val),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .fwd_val(head_rs1_fwd)
    );
    alu_fwd_sel u_head_rs2 (
        .rs(head.rs2), .file_val(head.rs2val),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .fwd_val(head_rs2_fwd)
    );
    alu_fwd_sel u_skid_rs1 (
        .rs(skid.rs1), .file_val(skid.rs1val),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .fwd_val(skid_rs1_fwd)
    );
    alu_fwd_sel u_skid_rs2 (
        .rs(skid.rs2), .file_val(skid.rs2val),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .fwd_val(skid_rs2_fwd)
    );
`else
    // Hazards are resolved upstream by stalling, so the bypass ports are deliberately left unused.
    logic unused_bypass;
    assign unused_bypass = ^{exm_we, exm_rd, exm_data, mwb_we, mwb_rd, mwb_data};

    assign in_rs1_fwd   = in_rs1_data;
    assign in_rs2_fwd   = in_rs2_data;
    assign head_rs1_fwd = head.rs1val;
    assign head_rs2_fwd = head.rs2val;
    assign skid_rs1_fwd = skid.rs1val;
    assign skid_rs2_fwd = skid.rs2val;
`endif

    always_comb begin
        in_entry.rs1val  = in_rs1_fwd;
        in_entry.rs2val  = in_rs2_fwd;
        in_entry.imm     = in_imm;
        in_entry.pc      = in_pc;
        in_entry.rs1     = in_rs1;
        in_entry.rs2     = in_rs2;
        in_entry.rd      = in_rd;
        in_entry.op      = in_alu_op;
        in_entry.use_pc  = in_use_pc;
        in_entry.use_imm = in_use_imm;

        head_fwd         = head;
        head_fwd.rs1val  = head_rs1_fwd;
        head_fwd.rs2val  = head_rs2_fwd;
        skid_fwd         = skid;
        skid_fwd.rs1val  = skid_rs1_fwd;
        skid_fwd.rs2val  = skid_rs2_fwd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY:   if (in_fire) state_nxt = ONE;
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_nxt = TWO;
                    end else if (out_fire && !in_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO:     if (out_fire) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Ready depends only on the state register, so out_ready never reaches in_ready combinationally.
    always_comb begin
        in_ready  = (state != TWO);
        out_valid = (state != EMPTY);
    end

    // Valid entries keep snooping every cycle; invalid entries simply hold whatever they last had.
    always_comb begin
        head_nxt = (state == EMPTY) ? head : head_fwd;
        skid_nxt = (state == TWO) ? skid_fwd : skid;
        unique case (state)
            EMPTY: begin
                if (in_fire) head_nxt = in_entry;
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    head_nxt = in_entry;
                end else if (in_fire) begin
                    skid_nxt = in_entry;
                end
            end
            TWO: begin
                if (out_fire) head_nxt = skid_fwd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
        end else begin
            head <= head_nxt;
            skid <= skid_nxt;
        end
    end

    assign dataA  = head.use_pc  ? head.pc  : head.rs1val;
    assign dataB  = head.use_imm ? head.imm : head.rs2val;
    assign alu_op = head.op;
    assign out_rd = head.rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus a randomized run against a queue model.
module tb_alu_operand_stage;
    import rv32_alu_pkg::*;

`ifdef ALU_STAGE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush, in_valid, in_ready;
    logic [XLEN-1:0]  in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic [REGAW-1:0] in_rs1, in_rs2, in_rd;
    logic [OPW-1:0]   in_alu_op;
    logic             in_use_pc, in_use_imm;
    logic             exm_we, mwb_we;
    logic [REGAW-1:0] exm_rd, mwb_rd;
    logic [XLEN-1:0]  exm_data, mwb_data;
    logic             out_valid, out_ready;
    logic [XLEN-1:0]  dataA, dataB;
    logic [OPW-1:0]   alu_op;
    logic [REGAW-1:0] out_rd;

    int vectors = 0;
    int miscompares = 0;
    opstage_entry_t model_q[$];

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_alu_op(in_alu_op), .in_use_pc(in_use_pc), .in_use_imm(in_use_imm),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .dataA(dataA), .dataB(dataB), .alu_op(alu_op), .out_rd(out_rd)
    );

    // Register value as seen after this cycle's writebacks.
    function automatic logic [XLEN-1:0] ref_fwd(input logic [REGAW-1:0] rs, input logic [XLEN-1:0] v);
        if (FWD && rs != 0 && exm_we && exm_rd == rs) return exm_data;
        if (FWD && rs != 0 && mwb_we && mwb_rd == rs) return mwb_data;
        return v;
    endfunction

    // Queue model of one rising edge: snoop held entries, pop, then flush or push.
    task automatic model_step();
        bit in_fire, out_fire;
        opstage_entry_t e;
        in_fire  = in_valid && (model_q.size() < 2) && !flush;
        out_fire = out_ready && (model_q.size() > 0);
        foreach (model_q[i]) begin
            model_q[i].rs1val = ref_fwd(model_q[i].rs1, model_q[i].rs1val);
            model_q[i].rs2val = ref_fwd(model_q[i].rs2, model_q[i].rs2val);
        end
        if (out_fire) void'(model_q.pop_front());
        if (flush) begin
            model_q.delete();
        end else if (in_fire) begin
            e.rs1val = ref_fwd(in_rs1, in_rs1_data);
            e.rs2val = ref_fwd(in_rs2, in_rs2_data);
            e.imm = in_imm; e.pc = in_pc;
            e.rs1 = in_rs1; e.rs2 = in_rs2; e.rd = in_rd;
            e.op = in_alu_op; e.use_pc = in_use_pc; e.use_imm = in_use_imm;
            model_q.push_back(e);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exm_we = 1'b0; exm_rd = '0; exm_data = '0;
        mwb_we = 1'b0; mwb_rd = '0; mwb_data = '0;
        in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_pc = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_alu_op = '0;
        in_use_pc = 1'b0; in_use_imm = 1'b0;
    endtask

    task automatic drive_entry(input logic [XLEN-1:0] rs1d, input logic [XLEN-1:0] rs2d,
                               input logic [REGAW-1:0] rs1, input logic [REGAW-1:0] rs2,
                               input logic [REGAW-1:0] rd, input logic [OPW-1:0] op);
        in_valid = 1'b1;
        in_rs1_data = rs1d; in_rs2_data = rs2d;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_alu_op = op;
        in_use_pc = 1'b0; in_use_imm = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        vectors++; if (alu_op !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_alu_op: got %h want 0", alu_op); end
        vectors++; if (out_rd !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_out_rd: got %0d want 0", out_rd); end
        vectors++; if (dataA !== 32'h0 || dataB !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_data: got %h/%h want 0/0", dataA, dataB); end
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
    endtask

    task automatic test_basic();
        set_idle();
        drive_entry(32'd4, 32'd2, 5'd1, 5'd2, 5'd3, 4'h0);
        out_ready = 1'b1;
        cycle();
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_valid: got %b want 1", out_valid); end
        vectors++; if (dataA !== 32'd4 || dataB !== 32'd2) begin miscompares++; $display("[TB] FAIL basic_data: got %h/%h want 4/2", dataA, dataB); end
        vectors++; if (alu_op !== 4'h0 || out_rd !== 5'd3) begin miscompares++; $display("[TB] FAIL basic_op_rd: got %h/%0d want 0/3", alu_op, out_rd); end
        in_valid = 1'b0;
        cycle();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        set_idle();
        drive_entry(32'h11, 32'h0, 5'd1, 5'd0, 5'd1, 4'h1);
        cycle();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_ready_one: got %b want 1", in_ready); end
        drive_entry(32'h22, 32'h0, 5'd1, 5'd0, 5'd2, 4'h2);
        cycle();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_ready_two: got %b want 0", in_ready); end
        drive_entry(32'h33, 32'h0, 5'd1, 5'd0, 5'd3, 4'h3);
        cycle();
        vectors++; if (in_ready !== 1'b0 || dataA !== 32'h11 || out_rd !== 5'd1) begin
            miscompares++; $display("[TB] FAIL bp_head: got ready=%b dataA=%h rd=%0d want 0/11/1", in_ready, dataA, out_rd); end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        vectors++; if (out_valid !== 1'b1 || dataA !== 32'h22 || out_rd !== 5'd2 || in_ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL bp_second: got valid=%b dataA=%h rd=%0d ready=%b want 1/22/2/1", out_valid, dataA, out_rd, in_ready); end
        cycle();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_third_dropped: got valid=%b dataA=%h want valid 0", out_valid, dataA); end
    endtask

    task automatic test_forward();
        set_idle();
        drive_entry(32'h1, 32'h2, 5'd5, 5'd6, 5'd7, 4'h0);
        cycle();
        in_valid = 1'b0;
        exm_we = 1'b1; exm_rd = 5'd5; exm_data = 32'hAA;
        mwb_we = 1'b1; mwb_rd = 5'd5; mwb_data = 32'hBB;
        cycle();
        vectors++; if (dataA !== (FWD ? 32'hAA : 32'h1)) begin
            miscompares++; $display("[TB] FAIL fwd_exm_priority: got %h want %h", dataA, FWD ? 32'hAA : 32'h1); end
        exm_rd = 5'd9; mwb_rd = 5'd6; mwb_data = 32'hCC;
        cycle();
        vectors++; if (dataB !== (FWD ? 32'hCC : 32'h2) || dataA !== (FWD ? 32'hAA : 32'h1)) begin
            miscompares++; $display("[TB] FAIL fwd_mwb: got %h/%h want %h/%h", dataA, dataB, FWD ? 32'hAA : 32'h1, FWD ? 32'hCC : 32'h2); end
        exm_we = 1'b0; mwb_we = 1'b0; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        drive_entry(32'h0, 32'h9, 5'd0, 5'd0, 5'd1, 4'h0);
        exm_we = 1'b1; exm_rd = 5'd0; exm_data = 32'hFF;
        mwb_we = 1'b1; mwb_rd = 5'd0; mwb_data = 32'hEE;
        cycle();
        in_valid = 1'b0;
        cycle();
        vectors++; if (dataA !== 32'h0 || dataB !== 32'h9) begin
            miscompares++; $display("[TB] FAIL fwd_x0: got %h/%h want 0/9", dataA, dataB); end
        set_idle(); out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_pc_imm();
        set_idle();
        drive_entry(32'h7, 32'h8, 5'd1, 5'd2, 5'd4, 4'hC);
        in_use_pc = 1'b1; in_pc = 32'h100;
        in_use_imm = 1'b1; in_imm = 32'hFFFF_FFFC;
        out_ready = 1'b1;
        cycle();
        vectors++; if (dataA !== 32'h100 || dataB !== 32'hFFFF_FFFC) begin
            miscompares++; $display("[TB] FAIL pc_imm: got %h/%h want 100/fffffffc", dataA, dataB); end
        vectors++; if (alu_op !== 4'hC) begin miscompares++; $display("[TB] FAIL undef_op_pass: got %h want c", alu_op); end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_flush();
        set_idle();
        drive_entry(32'h61, 32'h0, 5'd1, 5'd0, 5'd1, 4'h0);
        cycle();
        drive_entry(32'h62, 32'h0, 5'd1, 5'd0, 5'd2, 4'h0);
        cycle();
        drive_entry(32'hDEAD, 32'h0, 5'd1, 5'd0, 5'd3, 4'h0);
        flush = 1'b1;
        cycle();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL flush_state: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
        flush = 1'b0; in_valid = 1'b0;
        cycle();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_dropped: got valid=%b dataA=%h want 0", out_valid, dataA); end
        drive_entry(32'h55, 32'h0, 5'd1, 5'd0, 5'd4, 4'h0);
        out_ready = 1'b1;
        cycle();
        vectors++; if (out_valid !== 1'b1 || dataA !== 32'h55) begin
            miscompares++; $display("[TB] FAIL flush_refill: got valid=%b dataA=%h want 1/55", out_valid, dataA); end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_async_reset();
        set_idle();
        drive_entry(32'h77, 32'h78, 5'd1, 5'd2, 5'd9, 4'h5);
        cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || dataA !== 32'h0 || out_rd !== 5'd0) begin
            miscompares++; $display("[TB] FAIL async_reset: got valid=%b ready=%b dataA=%h rd=%0d want 0/1/0/0", out_valid, in_ready, dataA, out_rd); end
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        opstage_entry_t h;
        logic [XLEN-1:0] exp_a, exp_b;
        set_idle();
        for (int n = 0; n < 400; n++) begin
            vectors++; if (out_valid !== (model_q.size() > 0)) begin
                miscompares++; $display("[TB] FAIL rnd_valid[%0d]: got %b want %b", n, out_valid, model_q.size() > 0); end
            vectors++; if (in_ready !== (model_q.size() < 2)) begin
                miscompares++; $display("[TB] FAIL rnd_ready[%0d]: got %b want %b", n, in_ready, model_q.size() < 2); end
            if (model_q.size() > 0) begin
                h = model_q[0];
                exp_a = h.use_pc ? h.pc : h.rs1val;
                exp_b = h.use_imm ? h.imm : h.rs2val;
                vectors++; if (dataA !== exp_a || dataB !== exp_b) begin
                    miscompares++; $display("[TB] FAIL rnd_data[%0d]: got %h/%h want %h/%h", n, dataA, dataB, exp_a, exp_b); end
                vectors++; if (alu_op !== h.op || out_rd !== h.rd) begin
                    miscompares++; $display("[TB] FAIL rnd_op_rd[%0d]: got %h/%0d want %h/%0d", n, alu_op, out_rd, h.op, h.rd); end
            end
            in_valid    = $urandom_range(0, 3) != 0;
            out_ready   = $urandom_range(0, 2) != 0;
            flush       = $urandom_range(0, 15) == 0;
            in_rs1_data = $urandom; in_rs2_data = $urandom;
            in_imm      = $urandom; in_pc = $urandom;
            in_rs1      = REGAW'($urandom_range(0, 3));
            in_rs2      = REGAW'($urandom_range(0, 3));
            in_rd       = REGAW'($urandom_range(0, 31));
            in_alu_op   = OPW'($urandom_range(0, 15));
            in_use_pc   = $urandom_range(0, 1) == 1;
            in_use_imm  = $urandom_range(0, 1) == 1;
            exm_we      = $urandom_range(0, 1) == 1;
            exm_rd      = REGAW'($urandom_range(0, 3));
            exm_data    = $urandom;
            mwb_we      = $urandom_range(0, 1) == 1;
            mwb_rd      = REGAW'($urandom_range(0, 3));
            mwb_data    = $urandom;
            cycle();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_forward();
        test_pc_imm();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
